// File: rtl/cinema_session_ctrl.sv
// Cinema session controller: time-filtered session FSM with seat booking,
// optional refunds (CINEMA_REFUND_EN) and a daily saturating revenue total.
// Ports: clk, rst_n, r_time_i {week,hour}, book_req/cancel_req/book_seat in;
//        state_o, session_o, seat_map_o, seats_left_o, ack_o, nack_o,
//        show_start_o, revenue_o out.
module cinema_session_ctrl #(
   parameter int unsigned PRICE_WEEKDAY = 3,
   parameter int unsigned PRICE_WEEKEND = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  r_time_i,
   input  logic        book_req,
   input  logic        cancel_req,
   input  logic [3:0]  book_seat,
   output logic [1:0]  state_o,
   output logic [1:0]  session_o,
   output logic [15:0] seat_map_o,
   output logic [4:0]  seats_left_o,
   output logic        ack_o,
   output logic        nack_o,
   output logic        show_start_o,
   output logic [11:0] revenue_o
);

   typedef enum logic [1:0] {
      ST_CLOSED  = 2'd0,
      ST_SELLING = 2'd1,
      ST_PLAYING = 2'd2
   } state_e;

   localparam logic [11:0] PW = 12'(PRICE_WEEKDAY);
   localparam logic [11:0] PE = 12'(PRICE_WEEKEND);

   state_e      state_q, state_d, map_st;
   logic [1:0]  session_q, session_d, map_ses;
   logic [9:0]  s1_q, cur_q, cur_d;
   logic [4:0]  day_q, day_d;
   logic [15:0] seat_q, seat_d;
   logic [4:0]  left_q, left_d;
   logic [11:0] rev_q, rev_d;
   logic        ack_q, ack_d, nack_q, nack_d, show_q, show_d;

   logic        upd, valid, sold, sell, req, do_book, do_cancel;
   logic [4:0]  nw, nh;
   logic [11:0] price;
   logic [12:0] sum;

   // cur only follows a time value that has been stable for two samples
   assign upd   = (r_time_i == s1_q) && (s1_q != cur_q);
   assign nw    = s1_q[9:5];
   assign nh    = s1_q[4:0];
   assign valid = (nw != 5'd0) && (nw <= 5'd7) && (nh <= 5'd9);

   // day_q is the week of the last valid time, so it selects the price
   assign price = (day_q >= 5'd6) ? PE : PW;
   assign sum   = {1'b0, rev_q} + {1'b0, price};
   assign sold  = seat_q[book_seat];
   assign sell  = (state_q == ST_SELLING) && !upd;

`ifdef CINEMA_REFUND_EN
   assign req       = book_req | cancel_req;
   assign do_cancel = cancel_req && !book_req && sell && sold;
`else
   assign req       = book_req;
   assign do_cancel = 1'b0;
`endif
   assign do_book = book_req && !cancel_req && sell && !sold;

   always_comb begin
      map_st  = ST_CLOSED;
      map_ses = session_q;
      if (valid) begin
         case (nh)
            5'd0, 5'd1: begin map_st = ST_SELLING; map_ses = 2'd0; end
            5'd2, 5'd3: begin map_st = ST_PLAYING; map_ses = 2'd0; end
            5'd4:       begin map_st = ST_SELLING; map_ses = 2'd1; end
            5'd5, 5'd6: begin map_st = ST_PLAYING; map_ses = 2'd1; end
            5'd7:       begin map_st = ST_SELLING; map_ses = 2'd2; end
            default:    begin map_st = ST_PLAYING; map_ses = 2'd2; end
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      session_d = session_q;
      cur_d     = cur_q;
      day_d     = day_q;
      seat_d    = seat_q;
      left_d    = left_q;
      rev_d     = rev_q;
      ack_d     = do_book | do_cancel;
      nack_d    = req & ~(do_book | do_cancel);
      show_d    = 1'b0;
      if (upd) begin
         cur_d     = s1_q;
         state_d   = map_st;
         session_d = map_ses;
         show_d    = (state_q == ST_SELLING) && (map_st == ST_PLAYING);
         if (valid) begin
            day_d = nw;
            if (nw != day_q) rev_d = 12'd0;
         end
         // a fresh sale opens for a new show or a new day
         if (map_st == ST_SELLING &&
             (state_q != ST_SELLING || map_ses != session_q ||
              nw != day_q)) begin
            seat_d = 16'd0;
            left_d = 5'd16;
         end
      end else if (do_book) begin
         seat_d = seat_q | (16'd1 << book_seat);
         left_d = left_q - 5'd1;
         rev_d  = sum[12] ? 12'hFFF : sum[11:0];
      end else if (do_cancel) begin
         seat_d = seat_q & ~(16'd1 << book_seat);
         left_d = left_q + 5'd1;
         rev_d  = (rev_q < price) ? 12'd0 : rev_q - price;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_SELLING;
         session_q <= 2'd0;
         s1_q      <= 10'h020;
         cur_q     <= 10'h020;
         day_q     <= 5'd1;
         seat_q    <= 16'd0;
         left_q    <= 5'd16;
         rev_q     <= 12'd0;
         ack_q     <= 1'b0;
         nack_q    <= 1'b0;
         show_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         session_q <= session_d;
         s1_q      <= r_time_i;
         cur_q     <= cur_d;
         day_q     <= day_d;
         seat_q    <= seat_d;
         left_q    <= left_d;
         rev_q     <= rev_d;
         ack_q     <= ack_d;
         nack_q    <= nack_d;
         show_q    <= show_d;
      end
   end

   assign state_o      = state_q;
   assign session_o    = session_q;
   assign seat_map_o   = seat_q;
   assign seats_left_o = left_q;
   assign ack_o        = ack_q;
   assign nack_o       = nack_q;
   assign show_start_o = show_q;
   assign revenue_o    = rev_q;

endmodule

// File: tb/tb_cinema_session_ctrl.sv
// Directed, table-driven bench for cinema_session_ctrl.
// Expectations follow the default or refund build via CINEMA_REFUND_EN.
module tb_cinema_session_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  r_time_i = 10'h020;
   logic        book_req = 1'b0;
   logic        cancel_req = 1'b0;
   logic [3:0]  book_seat = 4'd0;
   logic [1:0]  state_o, session_o;
   logic [15:0] seat_map_o;
   logic [4:0]  seats_left_o;
   logic        ack_o, nack_o, show_start_o;
   logic [11:0] revenue_o;

   int total = 0;
   int bad = 0;

`ifdef CINEMA_REFUND_EN
   localparam bit REF = 1'b1;
`else
   localparam bit REF = 1'b0;
`endif

   cinema_session_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .r_time_i     (r_time_i),
      .book_req     (book_req),
      .cancel_req   (cancel_req),
      .book_seat    (book_seat),
      .state_o      (state_o),
      .session_o    (session_o),
      .seat_map_o   (seat_map_o),
      .seats_left_o (seats_left_o),
      .ack_o        (ack_o),
      .nack_o       (nack_o),
      .show_start_o (show_start_o),
      .revenue_o    (revenue_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  t;
      bit          bk;
      bit          cn;
      logic [3:0]  seat;
      int          edges;
      logic [1:0]  st;
      logic [1:0]  ses;
      logic [15:0] map;
      logic [4:0]  left;
      logic [11:0] rev;
      bit          ack;
      bit          nack;
      bit          show;
   } vec_t;

   vec_t vq[$];

   function automatic logic [9:0] T(int w, int h);
      return {5'(w), 5'(h)};
   endfunction

   task automatic add(logic [9:0] t, bit bk, bit cn, int seat, int edges,
                      int st, int ses, int map, int left, int rev,
                      bit ack, bit nack, bit show);
      vec_t v;
      v.t = t; v.bk = bk; v.cn = cn; v.seat = 4'(seat);
      v.edges = edges; v.st = 2'(st); v.ses = 2'(ses);
      v.map = 16'(map); v.left = 5'(left); v.rev = 12'(rev);
      v.ack = ack; v.nack = nack; v.show = show;
      vq.push_back(v);
   endtask

   task automatic chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(string p, int st, int ses, int map, int left,
                          int rev, int ack, int nack, int show);
      chk({p, ".state"}, int'(state_o), st);
      chk({p, ".session"}, int'(session_o), ses);
      chk({p, ".map"}, int'(seat_map_o), map);
      chk({p, ".left"}, int'(seats_left_o), left);
      chk({p, ".rev"}, int'(revenue_o), rev);
      chk({p, ".ack"}, int'(ack_o), ack);
      chk({p, ".nack"}, int'(nack_o), nack);
      chk({p, ".show"}, int'(show_start_o), show);
   endtask

   // drive for one edge, release requests, let the rest of the edges pass
   task automatic step(logic [9:0] t, bit bk, bit cn, int seat, int edges);
      @(negedge clk);
      r_time_i = t; book_req = bk; cancel_req = cn; book_seat = 4'(seat);
      @(posedge clk);
      #1;
      book_req = 1'b0; cancel_req = 1'b0;
      for (int e = 1; e < edges; e++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int m, l, r, n, exp_rev;
      m = REF ? 0 : 'h20;
      l = REF ? 16 : 15;
      r = REF ? 0 : 3;
      add(T(1,0), 1,0, 3,1, 1,0,'h0008,15,3, 1,0,0);
      add(T(1,0), 1,0, 3,1, 1,0,'h0008,15,3, 0,1,0);
      add(T(1,0), 1,0,15,1, 1,0,'h8008,14,6, 1,0,0);
      add(T(1,1), 0,0, 0,2, 1,0,'h8008,14,6, 0,0,0);
      add(T(1,2), 0,0, 0,2, 2,0,'h8008,14,6, 0,0,1);
      add(T(1,2), 1,0, 1,1, 2,0,'h8008,14,6, 0,1,0);
      add(T(1,4), 0,0, 0,2, 1,1,0,16,6, 0,0,0);
      add(T(6,4), 0,0, 0,2, 1,1,0,16,0, 0,0,0);
      add(T(6,4), 1,0, 0,1, 1,1,1,15,5, 1,0,0);
      add(T(7,0), 0,0, 0,2, 1,0,0,16,0, 0,0,0);
      add(T(7,0), 1,1, 2,1, 1,0,0,16,0, 0,1,0);
      add(T(2,0), 0,0, 0,2, 1,0,0,16,0, 0,0,0);
      add(T(2,0), 0,1, 0,1, 1,0,0,16,0, 0,REF,0);
      add(T(2,0), 1,0, 5,1, 1,0,'h20,15,3, 1,0,0);
      add(T(2,0), 0,1, 5,1, 1,0,m,l,r, REF,0,0);
      add(T(0,12),0,0, 0,2, 0,0,m,l,r, 0,0,0);
      add(T(0,12),1,0, 1,1, 0,0,m,l,r, 0,1,0);
      add(T(2,1), 0,0, 0,2, 1,0,0,16,r, 0,0,0);

      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", 1, 0, 0, 16, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_all("release", 1, 0, 0, 16, 0, 0, 0, 0);

      foreach (vq[i]) begin
         step(vq[i].t, vq[i].bk, vq[i].cn, int'(vq[i].seat), vq[i].edges);
         chk_all($sformatf("v%0d", i), vq[i].st, vq[i].ses, vq[i].map,
                 vq[i].left, vq[i].rev, vq[i].ack, vq[i].nack, vq[i].show);
      end

      // one-cycle glitch on the time input must not move cur
      step(T(2,1), 1, 0, 7, 1);
      chk_all("book7", 1, 0, 'h80, 15, r + 3, 1, 0, 0);
      step(T(2,3), 0, 0, 0, 1);
      step(T(2,1), 0, 0, 0, 3);
      chk_all("glitch", 1, 0, 'h80, 15, r + 3, 0, 0, 0);

      // a request on the transition edge is nacked, transition proceeds
      step(T(2,2), 0, 0, 0, 1);
      step(T(2,2), 1, 0, 8, 1);
      chk_all("trans_req", 2, 0, 'h80, 15, r + 3, 0, 1, 1);

      // weekend bookings until revenue saturates
      step(T(6,4), 0, 0, 0, 2);
      chk_all("sat_start", 1, 1, 0, 16, 0, 0, 0, 0);
      n = 0;
      for (int s = 0; s < 52; s++) begin
         for (int k = 0; k < 16; k++) begin
            step(T(6,4), 1, 0, k, 1);
            n++;
            if (ack_o !== 1'b1)
               chk($sformatf("sat_ack%0d", n), int'(ack_o), 1);
         end
         exp_rev = (5 * n > 4095) ? 4095 : 5 * n;
         chk($sformatf("sat_rev%0d", s), int'(revenue_o), exp_rev);
         chk($sformatf("sat_left%0d", s), int'(seats_left_o), 0);
         step(T(6,5), 0, 0, 0, 2);
         step(T(6,4), 0, 0, 0, 2);
      end
      chk("sat_final", int'(revenue_o), 4095);

      // reset while a request is in flight
      @(negedge clk);
      book_req = 1'b1; book_seat = 4'd9;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("rst_async", 1, 0, 0, 16, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      book_req = 1'b0;
      chk_all("rst_hold", 1, 0, 0, 16, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_all("rst_rel", 1, 0, 0, 16, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk_all("rst_time", 1, 1, 0, 16, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
